decode_stage_pipe: RTL

//  Registered, handshaked instruction-decode pipeline stage for the 16-bit core; the next

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_ctrl_comb.sv | 75 +++++++
 rtl/decode_stage_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU operation codes,
// instruction field positions and the packed control bundle.
package decode_pkg;

  // Opcodes, instr[15:13]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SUBI = 3'b011;
  localparam logic [2:0] OP_LUI  = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_LW   = 3'b111;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_LUI = 3'b011;

  // Instruction field bit positions
  localparam int unsigned OpcMsb   = 15;
  localparam int unsigned OpcLsb   = 13;
  localparam int unsigned RaMsb    = 12;
  localparam int unsigned RaLsb    = 10;
  localparam int unsigned RbMsb    = 9;
  localparam int unsigned RbLsb    = 7;
  localparam int unsigned RcMsb    = 2;
  localparam int unsigned RcLsb    = 0;
  localparam int unsigned Imm7Msb  = 6;
  localparam int unsigned Imm10Msb = 9;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_comb.sv
// Pure combinational decoder: instruction -> control bundle, register indices
// and processed immediate.
//   instr  : 16-bit instruction
//   ctrl   : alu_op / reg_write / mem_read / mem_write / branch
//   rd, rs1, rs2 : register indices (0 = none)
//   imm    : sign-extended or LUI-shifted immediate, DATA_W wide
module decode_ctrl_comb
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [15:0]       instr,
  output ctrl_t             ctrl,
  output logic [2:0]        rd,
  output logic [2:0]        rs1,
  output logic [2:0]        rs2,
  output logic [DATA_W-1:0] imm
);

  logic [2:0]        opcode, ra, rb, rc;
  logic [DATA_W-1:0] sext7, sext10, lui_imm;

  assign opcode  = instr[OpcMsb:OpcLsb];
  assign ra      = instr[RaMsb:RaLsb];
  assign rb      = instr[RbMsb:RbLsb];
  assign rc      = instr[RcMsb:RcLsb];
  assign sext7   = {{(DATA_W-7){instr[Imm7Msb]}}, instr[Imm7Msb:0]};
  assign sext10  = {{(DATA_W-10){instr[Imm10Msb]}}, instr[Imm10Msb:0]};
  assign lui_imm = {instr[Imm10Msb:0], {(DATA_W-10){1'b0}}};

  always_comb begin
    ctrl = '0;
    rd   = 3'd0;
    rs1  = 3'd0;
    rs2  = 3'd0;
    imm  = '0;
    unique case (opcode)
      OP_ADD: begin
        ctrl.alu_op = ALU_ADD; ctrl.reg_write = 1'b1;
        rd = ra; rs1 = rb; rs2 = rc;
      end
      OP_ADDI: begin
        ctrl.alu_op = ALU_ADD; ctrl.reg_write = 1'b1;
        rd = ra; rs1 = rb; imm = sext7;
      end
      OP_SUB: begin
        ctrl.alu_op = ALU_SUB; ctrl.reg_write = 1'b1;
        rd = ra; rs1 = rb; rs2 = rc;
      end
      OP_SUBI: begin
        ctrl.alu_op = ALU_SUB; ctrl.reg_write = 1'b1;
        rd = ra; rs1 = ra; imm = sext10;
      end
      OP_LUI: begin
        ctrl.alu_op = ALU_LUI; ctrl.reg_write = 1'b1;
        rd = ra; imm = lui_imm;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1;
        rs1 = ra; rs2 = rb; imm = sext7;
      end
      OP_SW: begin
        // rs1 is the base address, rs2 the store data
        ctrl.alu_op = ALU_ADD; ctrl.mem_write = 1'b1;
        rs1 = rb; rs2 = ra; imm = sext7;
      end
      OP_LW: begin
        ctrl.alu_op = ALU_ADD; ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1;
        rd = ra; rs1 = rb; imm = sext7;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered, valid/ready handshaked decode stage between fetch and execute.
// Inserts load-use bubbles after LW for LOAD_DELAY cycles.
//   clk, rst_n          : clock, async active-low reset
//   flush               : kills held bundle and pending hazard on next edge
//   in_valid/in_ready   : fetch-side handshake, instr is the offered word
//   out_valid/out_ready : execute-side handshake
//   alu_op..imm         : registered decoded bundle (jump is reserved, always 0)
// DATA_W must be >= 16; LOAD_DELAY must be 0..3.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LOAD_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        alu_op,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic [2:0]        rd,
  output logic [2:0]        rs1,
  output logic [2:0]        rs2,
  output logic [DATA_W-1:0] imm
);

  localparam logic [1:0] HazInit = 2'(LOAD_DELAY);

  ctrl_t             dec_ctrl, ctrl_q, ctrl_d;
  logic [2:0]        dec_rd, dec_rs1, dec_rs2;
  logic [DATA_W-1:0] dec_imm, imm_q, imm_d;
  logic [2:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        haz_cnt_q, haz_cnt_d;
  logic [2:0]        pend_rd_q, pend_rd_d;
  logic              stall, accept;

  decode_ctrl_comb #(
    .DATA_W(DATA_W)
  ) u_dec (
    .instr(instr),
    .ctrl (dec_ctrl),
    .rd   (dec_rd),
    .rs1  (dec_rs1),
    .rs2  (dec_rs2),
    .imm  (dec_imm)
  );

  // pend_rd is never 0 while a hazard is live, so index-0 sources never match
  assign stall = (haz_cnt_q != 2'd0) && in_valid && (pend_rd_q != 3'd0) &&
                 ((dec_rs1 == pend_rd_q) || (dec_rs2 == pend_rd_q));
  assign in_ready = (!out_valid_q || out_ready) && !stall && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    haz_cnt_d   = haz_cnt_q;
    pend_rd_d   = pend_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
      haz_cnt_d   = 2'd0;
    end else begin
      if (accept) begin
        out_valid_d = 1'b1;
        ctrl_d      = dec_ctrl;
        rd_d        = dec_rd;
        rs1_d       = dec_rs1;
        rs2_d       = dec_rs2;
        imm_d       = dec_imm;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      // A newer LW overrides any older pending hazard
      if (accept && dec_ctrl.mem_read && (dec_rd != 3'd0)) begin
        haz_cnt_d = HazInit;
        pend_rd_d = dec_rd;
      end else if (haz_cnt_q != 2'd0) begin
        haz_cnt_d = haz_cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= 3'd0;
      rs1_q       <= 3'd0;
      rs2_q       <= 3'd0;
      imm_q       <= '0;
      haz_cnt_q   <= 2'd0;
      pend_rd_q   <= 3'd0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      haz_cnt_q   <= haz_cnt_d;
      pend_rd_q   <= pend_rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = ctrl_q.alu_op;
  assign reg_write = ctrl_q.reg_write;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign branch    = ctrl_q.branch;
  assign jump      = 1'b0;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign imm       = imm_q;

endmodule
